dmem_responder: RTL

- Data-memory slave: the responder end of the memory-stage load/store interface. It receives the LSU's word address, store data and byte mask, and returns load data.
- Sits outside the core, between the core's memory-stage outputs and on-chip data RAM.
- Adds a valid/ready request/response handshake with programmable wait states, so the core can be exercised against slow memory.
- Flags out-of-range accesses.

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state, request/response bundles, lane count.
package dmem_responder_pkg;

    localparam int DMEM_DW    = 32;
    localparam int DMEM_AW    = 32;
    localparam int DMEM_LANES = DMEM_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DMEM_AW-1:0]    addr;
        logic [DMEM_DW-1:0]    wdata;
        logic [DMEM_LANES-1:0] mask;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_DW-1:0] rdata;
        logic               err;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-masked synchronous RAM: one read or write per enabled cycle, registered read, no reset.
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int LANES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [LANES-1:0]      mask,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [LANES-1:0][7:0] mem [DEPTH];

    // rdata keeps the last read word while idle; the responder gates it onto the bus
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i]) mem[idx][i] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with valid/ready handshakes, programmable wait states and out-of-range flagging.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DW,
    parameter int ADDR_WIDTH = DMEM_AW,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_mask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t     state;
    logic [3:0] cnt;
    dmem_req_t  req_q;
    dmem_req_t  cur;
    dmem_req_t  acc;
    dmem_resp_t resp;
    logic       valid_q;
    logic       err_q;
    logic       rd_q;
    logic       oor;
    logic       access_go;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign cur = '{we: req_we, addr: req_addr, wdata: req_wdata, mask: req_mask};

    // With zero wait states the access happens on the accept edge, so it uses the live request
    assign acc       = (state == IDLE) ? cur : req_q;
    assign access_go = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                       ((state == WAIT) && (cnt == 4'd0));
    assign oor       = |acc.addr[ADDR_WIDTH-1:IDX_W+2];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc.addr[1:0];

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (access_go && !oor),
        .we    (acc.we),
        .idx   (acc.addr[IDX_W+1:2]),
        .wdata (acc.wdata),
        .mask  (acc.mask),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            req_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= cur;
                        if (access_go) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= oor;
                            rd_q    <= !acc.we && !oor;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (access_go) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= oor;
                        rd_q    <= !acc.we && !oor;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        rd_q    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM output is only exposed for an in-range load, so stores, errors and idle read as zero
    assign resp.rdata = rd_q ? ram_rdata : '0;
    assign resp.err   = err_q;

    assign req_ready  = (state == IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = resp.rdata;
    assign resp_err   = resp.err;

endmodule
